// File: rtl/qam_symbol_mapper.sv
// ============================================================================
// Module      : qam_symbol_mapper
// Description : Turns a byte stream into QPSK or 16-QAM symbols. Each symbol
//               is held on the unsigned i/q amplitude outputs for SYM_CLKS
//               clocks. A one-byte holding register sits in front of a
//               shifter, so back-to-back bytes are sent without a gap.
// Ports       : clk        - single clock, rising edge
//               reset      - synchronous, active-high
//               din        - data byte to transmit
//               din_valid  - din holds a byte
//               din_ready  - holding register is empty (registered state)
//               mode       - 0 = QPSK (2 bits/symbol), 1 = 16-QAM (4 bits)
//               i, q       - registered in-phase / quadrature amplitudes
//               sym_strobe - one-cycle pulse on the first cycle of a symbol
//               active     - high while a symbol is being driven
//               underrun   - one-cycle pulse when output stops for lack of data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_symbol_mapper #(
    parameter int SYM_CLKS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       mode,
    output logic [7:0] i,
    output logic [7:0] q,
    output logic       sym_strobe,
    output logic       active,
    output logic       underrun
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic [7:0] c_LAST = 8'(SYM_CLKS - 1);

    // 16-QAM Gray-coded amplitude for one 2-bit axis value.
    function automatic logic [7:0] gray_level(input logic [1:0] v);
        logic [7:0] lvl;
        case (v)
            2'b00:   lvl = 8'h10;
            2'b01:   lvl = 8'h50;
            2'b11:   lvl = 8'hB0;
            default: lvl = 8'hF0;
        endcase
        return lvl;
    endfunction

    // {I, Q} for the symbol held in the top nibble of a byte.
    // QPSK uses nib[3:2]; 16-QAM uses the whole nibble.
    function automatic logic [15:0] map_sym(input logic [3:0] nib, input logic m);
        logic [15:0] s;
        if (m) begin
            s = {gray_level(nib[3:2]), gray_level(nib[1:0])};
        end else begin
            s = {(nib[3] ? 8'hE0 : 8'h20), (nib[2] ? 8'hE0 : 8'h20)};
        end
        return s;
    endfunction

    logic [0:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_hold_data;
    logic       r_hold_full;
    logic [7:0] r_shift;
    logic [1:0] r_left;
    logic       r_mode;
    logic [7:0] r_i;
    logic [7:0] r_q;
    logic       r_strobe;
    logic       r_active;
    logic       r_underrun;

    logic [0:0]  w_state_nx;
    logic [7:0]  w_cnt_nx;
    logic [7:0]  w_shift_nx;
    logic [1:0]  w_left_nx;
    logic        w_mode_nx;
    logic [7:0]  w_i_nx;
    logic [7:0]  w_q_nx;
    logic        w_strobe_nx;
    logic        w_active_nx;
    logic        w_underrun_nx;
    logic        w_load;
    logic        w_next_sym;
    logic [15:0] w_sym;
    logic        w_accept;
    logic        w_hold_full_nx;

    // Ready depends only on registered state, never on din_valid.
    assign din_ready = !r_hold_full;
    assign w_accept  = din_valid && !r_hold_full;

    // A load empties the holding register; an accept on the same edge
    // refills it, so the register ends full.
    assign w_hold_full_nx = (r_hold_full && !w_load) || w_accept;

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_shift_nx    = r_shift;
        w_left_nx     = r_left;
        w_mode_nx     = r_mode;
        w_i_nx        = r_i;
        w_q_nx        = r_q;
        w_strobe_nx   = 1'b0;
        w_active_nx   = r_active;
        w_underrun_nx = 1'b0;
        w_load        = 1'b0;
        w_next_sym    = 1'b0;
        w_sym         = 16'h0000;

        case (r_state)
            c_IDLE: begin
                w_i_nx      = 8'h00;
                w_q_nx      = 8'h00;
                w_active_nx = 1'b0;
                w_cnt_nx    = 8'h00;
                w_load      = r_hold_full;
            end
            c_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nx = 8'h00;
                    if (r_left != 2'd0) begin
                        w_next_sym = 1'b1;
                    end else if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nx    = c_IDLE;
                        w_i_nx        = 8'h00;
                        w_q_nx        = 8'h00;
                        w_active_nx   = 1'b0;
                        w_underrun_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase

        // Shifter load: mode is sampled here only, so later changes on the
        // mode pin cannot affect the byte already in flight.
        if (w_load) begin
            w_state_nx  = c_RUN;
            w_cnt_nx    = 8'h00;
            w_mode_nx   = mode;
            w_sym       = map_sym(r_hold_data[7:4], mode);
            w_shift_nx  = mode ? {r_hold_data[3:0], 4'h0} : {r_hold_data[5:0], 2'b00};
            w_left_nx   = mode ? 2'd1 : 2'd3;
            w_i_nx      = w_sym[15:8];
            w_q_nx      = w_sym[7:0];
            w_strobe_nx = 1'b1;
            w_active_nx = 1'b1;
        end

        // Next symbol of the current byte always sits in the shifter MSBs.
        if (w_next_sym) begin
            w_sym       = map_sym(r_shift[7:4], r_mode);
            w_shift_nx  = r_mode ? {r_shift[3:0], 4'h0} : {r_shift[5:0], 2'b00};
            w_left_nx   = r_left - 2'd1;
            w_i_nx      = w_sym[15:8];
            w_q_nx      = w_sym[7:0];
            w_strobe_nx = 1'b1;
            w_active_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 8'h00;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_left      <= 2'd0;
            r_mode      <= 1'b0;
            r_i         <= 8'h00;
            r_q         <= 8'h00;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_hold_full <= w_hold_full_nx;
            if (w_accept) begin
                r_hold_data <= din;
            end
            r_shift     <= w_shift_nx;
            r_left      <= w_left_nx;
            r_mode      <= w_mode_nx;
            r_i         <= w_i_nx;
            r_q         <= w_q_nx;
            r_strobe    <= w_strobe_nx;
            r_active    <= w_active_nx;
            r_underrun  <= w_underrun_nx;
        end
    end

    assign i          = r_i;
    assign q          = r_q;
    assign sym_strobe = r_strobe;
    assign active     = r_active;
    assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_qam_symbol_mapper.sv
// ============================================================================
// Module      : tb_qam_symbol_mapper
// Description : Self-checking bench for qam_symbol_mapper (SYM_CLKS = 4).
//               A queue of expected {I,Q} symbols is filled whenever a byte
//               is accepted and consumed on every sym_strobe; a per-cycle
//               monitor also checks dwell time, idle levels, underrun and
//               reset behaviour. Directed steps are followed by random bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qam_symbol_mapper;

    localparam int SYM_CLKS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       mode = 1'b0;
    logic [7:0] i;
    logic [7:0] q;
    logic       sym_strobe;
    logic       active;
    logic       underrun;

    qam_symbol_mapper #(.SYM_CLKS(SYM_CLKS)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .i          (i),
        .q          (q),
        .sym_strobe (sym_strobe),
        .active     (active),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int underrun_cnt = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  lvl16 [4] = '{8'h10, 8'h50, 8'hF0, 8'hB0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- per-cycle monitor and reference model ----------------
    logic        ready_prev = 1'b0;
    logic        was_active = 1'b0;
    int          since = 0;
    logic [15:0] cur = 16'h0000;
    logic        a_acc, a_rst, a_mode;
    logic [7:0]  a_din, nib, pr;
    int          new_n;
    logic [15:0] e;

    always begin
        @(posedge clk);
        a_acc  = din_valid && ready_prev && !reset;
        a_rst  = reset;
        a_din  = din;
        a_mode = mode;
        #1;
        if (a_rst) begin
            exp_q.delete();
            chk("rst_iq", {i, q}, 32'h0);
            chk("rst_strobe", sym_strobe, 1'b0);
            chk("rst_active", active, 1'b0);
            chk("rst_underrun", underrun, 1'b0);
            chk("rst_ready", din_ready, 1'b1);
            since = 0;
            was_active = 1'b0;
        end else begin
            new_n = 0;
            if (a_acc) begin
                if (a_mode) begin
                    for (int k = 0; k < 2; k++) begin
                        nib = (a_din >> (4 - 4 * k)) & 8'h0F;
                        exp_q.push_back({lvl16[nib[3:2]], lvl16[nib[1:0]]});
                    end
                    new_n = 2;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        pr = (a_din >> (6 - 2 * k)) & 8'h03;
                        exp_q.push_back({(pr[1] ? 8'hE0 : 8'h20), (pr[0] ? 8'hE0 : 8'h20)});
                    end
                    new_n = 4;
                end
            end
            if (was_active) since++;
            if (sym_strobe) begin
                chk("strobe_has_data", exp_q.size() > new_n, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sym_i", i, e[15:8]);
                    chk("sym_q", q, e[7:0]);
                end
                if (was_active) chk("sym_dwell", since, SYM_CLKS);
                chk("strobe_active", active, 1'b1);
                chk("strobe_underrun", underrun, 1'b0);
                since = 0;
                cur = {i, q};
            end else if (underrun) begin
                underrun_cnt++;
                chk("underrun_after_run", was_active, 1'b1);
                chk("underrun_dwell", since, SYM_CLKS);
                chk("underrun_active", active, 1'b0);
                chk("underrun_iq", {i, q}, 32'h0);
                chk("underrun_starved", exp_q.size(), new_n);
            end else if (active) begin
                chk("run_continues", was_active, 1'b1);
                chk("run_dwell_max", since < SYM_CLKS, 1'b1);
                chk("run_hold_iq", {i, q}, cur);
            end else begin
                chk("idle_iq", {i, q}, 32'h0);
                chk("idle_no_silent_stop", was_active, 1'b0);
                chk("idle_latency", exp_q.size(), new_n);
            end
            was_active = active;
        end
        ready_prev = din_ready;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [7:0] b, input logic m);
        int t = 0;
        while (din_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("send_ready_timeout", din_ready, 1'b1);
        din       = b;
        mode      = m;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(active === 1'b0 && din_ready === 1'b1 && exp_q.size() == 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_active", active, 1'b0);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_strobe();
        int t = 0;
        while (sym_strobe !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("strobe_timeout", sym_strobe, 1'b1);
    endtask

    // ---------------- directed then random sequence ----------------
    int u0;
    int gap;
    logic [7:0] rb;
    logic       rm;

    initial begin
        // Reset for two cycles
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_i", i, 8'h00);
        chk("reset_q", q, 8'h00);
        chk("reset_ready", din_ready, 1'b1);
        chk("reset_active", active, 1'b0);
        chk("reset_strobe", sym_strobe, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // QPSK 8'hB4: first symbol one clock after accept, then underrun
        u0 = underrun_cnt;
        send(8'hB4, 1'b0);
        din_valid = 1'b0;
        chk("b4_accept_active", active, 1'b0);
        chk("b4_accept_ready", din_ready, 1'b0);
        @(negedge clk);
        chk("b4_first_strobe", sym_strobe, 1'b1);
        chk("b4_first_i", i, 8'hE0);
        chk("b4_first_q", q, 8'h20);
        wait_idle();
        chk("b4_underrun_count", underrun_cnt, u0 + 1);

        // 16-QAM 8'h3C
        u0 = underrun_cnt;
        send(8'h3C, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);
        chk("3c_first_iq", {i, q}, {8'h10, 8'hB0});
        wait_idle();
        chk("3c_underrun_count", underrun_cnt, u0 + 1);

        // QPSK 8'hFF then 8'h00 with din_valid held high: gap-free
        u0 = underrun_cnt;
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        chk("ff00_ready_low", din_ready, 1'b0);
        din_valid = 1'b0;
        wait_idle();
        chk("ff00_single_underrun", underrun_cnt, u0 + 1);

        // Mode toggled during the first 16-QAM symbol; next byte is QPSK
        send(8'h9C, 1'b1);
        din_valid = 1'b0;
        wait_strobe();
        mode = 1'b0;
        send(8'h1E, 1'b0);
        din_valid = 1'b0;
        wait_idle();

        // Random bytes, modes and gaps
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rm = 1'($urandom_range(0, 1));
            send(rb, rm);
            din_valid = 1'b0;
            gap = $urandom_range(0, 12);
            repeat (gap) @(negedge clk);
        end
        wait_idle();

        // Reset mid-symbol with a byte pending: both bytes discarded
        u0 = underrun_cnt;
        send(8'hC3, 1'b1);
        send(8'h5A, 1'b0);
        din_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_iq", {i, q}, 32'h0);
        chk("midrst_active", active, 1'b0);
        chk("midrst_ready", din_ready, 1'b1);
        chk("midrst_underrun", underrun, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_stays_idle", active, 1'b0);
        chk("midrst_no_underrun", underrun_cnt, u0);
        send(8'h2D, 1'b0);
        din_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
